// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and baud divisor helper.
// Used by the TX serialiser and the future RX block.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Truncating divide: the bit period is rounded down to whole clocks.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_ser_if.sv
// Byte handshake into the UART transmitter: byte moves on an edge where tx_valid & tx_ready.
// Producer drives the master side; the transmitter FIFO is the slave and refuses bytes when full.
interface uart_tx_ser_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the serialiser; write takes effect on the edge, head read is combinational.
// Backpressure: push ignored when full (even with a simultaneous pop), pop ignored when empty.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_ser.sv
// 8N1 UART transmitter behind a small byte FIFO; txd falls one edge after a byte lands in an idle, empty queue.
// Backpressure: tx_ready = FIFO not full; frames run back-to-back while the FIFO holds data.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  uart_tx_ser_if.slave                      tx_if,
  output logic                              txd,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW           = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_ser: CLK_FREQ/BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_ser: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e            state, state_nxt;
  logic [CW-1:0]        baud_cnt, baud_cnt_nxt;
  logic [BW-1:0]        bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 txd_nxt;
  logic                 busy_nxt;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 bit_tick;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_if.tx_valid),
    .wr_data (tx_if.tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign tx_if.tx_ready = !fifo_full;
  assign bit_tick       = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      txd      <= txd_nxt;
      tx_busy  <= busy_nxt;
    end
  end

  // txd/tx_busy are computed one edge ahead so the line changes exactly with the state.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = (state == IDLE || bit_tick) ? '0 : baud_cnt + CW'(1);
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    txd_nxt      = txd;
    busy_nxt     = tx_busy;
    fifo_pop     = 1'b0;

    case (state)
      IDLE: begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_nxt    = fifo_head;
          baud_cnt_nxt = '0;
          state_nxt    = START;
          txd_nxt      = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          txd_nxt     = shift[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_nxt = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + BW'(1);
            txd_nxt     = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_nxt = fifo_head;
            state_nxt = START;
            txd_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser at 16 clocks per bit: reset, single frame, burst, full-FIFO pop, mid-frame reset, encoder sweep.
// Serial line is decoded by a mid-bit sampling model; all expected bytes and timings are hand-computed.
module tb_uart_tx_ser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txd;
  logic       tx_busy;
  logic [2:0] fifo_level;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  uart_tx_ser_if tx_if ();

  uart_tx_ser #(
    .CLK_FREQ   (16),
    .BAUD       (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_if      (tx_if),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Nibble-to-hex-ASCII encoder model (lowercase, bit 8 always 0).
  function automatic logic [8:0] hex_enc(input logic [3:0] n);
    if (n < 4'd10) return {1'b0, 8'h30 + {4'h0, n}};
    return {1'b0, 8'h61 + {4'h0, n} - 8'd10};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    while (tx_if.tx_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
  endtask

  // Serial receiver: sample each bit at its middle (cycle 8 of 16).
  task automatic decode_frame(output logic [7:0] b, output bit ok);
    int t = 0;
    ok = 1'b1;
    b  = '0;
    while (txd !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (8) @(negedge clk);
    if (txd !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (16) @(negedge clk);
      b[k] = txd;
    end
    repeat (16) @(negedge clk);
    if (txd !== 1'b1) ok = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((tx_busy !== 1'b0 || fifo_level !== 3'd0) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (txd !== 1'b1 || tx_busy !== 1'b0) $display("FAIL reset_line: txd=%b busy=%b, want 1 0", txd, tx_busy);
    else pass_cnt++;
    chk_cnt++;
    if (tx_if.tx_ready !== 1'b1 || fifo_level !== 3'd0) $display("FAIL reset_fifo: ready=%b level=%0d, want 1 0", tx_if.tx_ready, fifo_level);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (txd !== 1'b1 || tx_busy !== 1'b0) $display("FAIL reset_idle: txd=%b busy=%b, want 1 0", txd, tx_busy);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [9:0] exp_bits;
    logic [9:0] seen_first;
    int bad = 0;
    int busy_cnt = 0;
    exp_bits = 10'b1001101010; // bit i = i-th line symbol: start, 1,0,1,0,1,1,0,0, stop
    push_byte(8'h35);
    tx_if.tx_valid = 1'b0;
    chk_cnt++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd1)
      $display("FAIL single_accept: txd=%b busy=%b level=%0d, want 1 0 1", txd, tx_busy, fifo_level);
    else pass_cnt++;
    seen_first = '0;
    for (int i = 1; i <= 170; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b1) busy_cnt++;
      if (i == 1) seen_first = {8'h00, txd, tx_busy};
      if (i <= 160) begin
        if (txd !== exp_bits[(i-1)/16]) bad++;
      end else if (txd !== 1'b1) bad++;
    end
    chk_cnt++;
    if (seen_first[1:0] !== 2'b01) $display("FAIL single_latency: txd,busy one edge after accept=%b, want 01", seen_first[1:0]);
    else pass_cnt++;
    chk_cnt++;
    if (bad != 0) $display("FAIL single_txd_seq: %0d wrong samples, want 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if (busy_cnt != 160) $display("FAIL single_busy: busy for %0d cycles, want 160", busy_cnt);
    else pass_cnt++;
    wait_idle();
  endtask

  task automatic test_burst();
    string exp_s = "01234";
    int busy_cnt = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          push_byte(8'h30 + 8'(i));
          if (i == 1) begin
            chk_cnt++;
            if (tx_busy !== 1'b1 || txd !== 1'b0 || fifo_level !== 3'd1)
              $display("FAIL burst_first_pop: busy=%b txd=%b level=%0d, want 1 0 1", tx_busy, txd, fifo_level);
            else pass_cnt++;
          end
        end
        tx_if.tx_valid = 1'b0;
        chk_cnt++;
        if (fifo_level !== 3'd4 || tx_if.tx_ready !== 1'b0)
          $display("FAIL burst_full: level=%0d ready=%b, want 4 0", fifo_level, tx_if.tx_ready);
        else pass_cnt++;
      end
      begin
        logic [7:0] b;
        bit ok;
        for (int k = 0; k < 5; k++) begin
          decode_frame(b, ok);
          chk_cnt++;
          if (!ok || b !== 8'(exp_s[k])) $display("FAIL burst_char%0d: got 0x%02h ok=%0b, want 0x%02h", k, b, ok, 8'(exp_s[k]));
          else pass_cnt++;
        end
      end
      begin
        for (int t = 0; t < 2000; t++) begin
          @(negedge clk);
          if (tx_busy === 1'b1) busy_cnt++;
          else if (busy_cnt > 0) break;
        end
      end
    join
    chk_cnt++;
    if (busy_cnt != 800) $display("FAIL burst_length: busy for %0d cycles, want 800", busy_cnt);
    else pass_cnt++;
    wait_idle();
  endtask

  task automatic test_full_pop();
    string exp_s = "ABCDEF";
    fork
      begin
        int t = 0;
        for (int i = 0; i < 5; i++) push_byte(8'h41 + 8'(i));
        tx_if.tx_data  = 8'h46;
        tx_if.tx_valid = 1'b1;
        while (tx_if.tx_ready !== 1'b1 && t < 400) begin
          @(negedge clk);
          t++;
        end
        chk_cnt++;
        if (fifo_level !== 3'd3 || txd !== 1'b0 || t < 100)
          $display("FAIL full_pop_refuse: level=%0d txd=%b wait=%0d, want 3 0 >=100", fifo_level, txd, t);
        else pass_cnt++;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        chk_cnt++;
        if (fifo_level !== 3'd4 || tx_if.tx_ready !== 1'b0)
          $display("FAIL full_pop_accept: level=%0d ready=%b, want 4 0", fifo_level, tx_if.tx_ready);
        else pass_cnt++;
      end
      begin
        logic [7:0] b;
        bit ok;
        for (int k = 0; k < 6; k++) begin
          decode_frame(b, ok);
          chk_cnt++;
          if (!ok || b !== 8'(exp_s[k])) $display("FAIL full_pop_char%0d: got 0x%02h ok=%0b, want 0x%02h", k, b, ok, 8'(exp_s[k]));
          else pass_cnt++;
        end
      end
    join
    wait_idle();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    bit ok;
    int bad = 0;
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    tx_if.tx_valid = 1'b0;
    repeat (71) @(negedge clk);   // middle of data bit 3 of 0x61 (a zero)
    chk_cnt++;
    if (txd !== 1'b0 || fifo_level !== 3'd2) $display("FAIL midframe_pre: txd=%b level=%0d, want 0 2", txd, fifo_level);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (txd !== 1'b1 || fifo_level !== 3'd0 || tx_busy !== 1'b0 || tx_if.tx_ready !== 1'b1)
      $display("FAIL midframe_reset: txd=%b level=%0d busy=%b ready=%b, want 1 0 0 1", txd, fifo_level, tx_busy, tx_if.tx_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL midframe_no_resume: %0d active samples after reset, want 0", bad);
    else pass_cnt++;
    push_byte(8'h66);
    tx_if.tx_valid = 1'b0;
    decode_frame(b, ok);
    chk_cnt++;
    if (!ok || b !== 8'h66) $display("FAIL midframe_after: got 0x%02h ok=%0b, want 0x66", b, ok);
    else pass_cnt++;
    wait_idle();
  endtask

  task automatic test_encoder_sweep();
    string exp_s = "0123456789abcdef";
    fork
      begin
        logic [8:0] enc;
        for (int n = 0; n < 16; n++) begin
          enc = hex_enc(4'(n));
          push_byte(enc[7:0]);
        end
        tx_if.tx_valid = 1'b0;
      end
      begin
        logic [7:0] b;
        bit ok;
        for (int k = 0; k < 16; k++) begin
          decode_frame(b, ok);
          chk_cnt++;
          if (!ok || b !== 8'(exp_s[k])) $display("FAIL sweep_char%0d: got 0x%02h ok=%0b, want 0x%02h", k, b, ok, 8'(exp_s[k]));
          else pass_cnt++;
        end
      end
    join
    wait_idle();
  endtask

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_full_pop();
    test_reset_midframe();
    test_encoder_sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
8N1 UART transmitter that consumes the ASCII bytes produced by the nibble-to-hex-ASCII encoder stage and serialises them onto the TX line.
- Front end: a small FIFO with a valid/ready handshake, so a burst of characters (e.g. a full hex dump) is absorbed without stalling the producer for every byte.
- Back end: a baud-rate tick counter and a frame FSM that drive a registered `txd`.
- Sits directly downstream of the encoder. The encoder's 9-bit output connects via bits [7:0]; bit 8 is unused and always 0.

Parameters:
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- FIFO_DEPTH, 4: byte entries; must be a power of two and ≥2.
- CLKS_PER_BIT (localparam) = CLK_FREQ/BAUD, integer-truncated (434 at defaults). Elaboration fails if it is <2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  ASCII byte to send; must be stable while tx_valid=1 and not yet accepted.
- tx_valid  in  1  producer has a byte.
- tx_ready  out  1  FIFO not full. Byte is accepted on an edge where tx_valid & tx_ready.
- txd  out  1  serial line, registered, idles high.
- tx_busy  out  1  high whenever the FSM is not IDLE.
- fifo_level  out  clog2(FIFO_DEPTH+1)  number of bytes currently queued.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - txd=1, tx_busy=0, tx_ready=1, fifo_level=0.
  - FSM=IDLE; baud counter, bit index and shift register cleared.
  - FIFO pointers cleared, i.e. queued data is discarded.
- Reset mid-frame: txd returns to 1 at once and the frame is truncated. After rst deasserts there is no partial-frame resume.
- FIFO:
  - tx_ready = !full, taken from current state only. When full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: level is unchanged, data order is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop occurs only under FSM control (see below).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is non-empty: pop, load the shift register, clear the baud counter, go to START. txd is driven 0 on that same edge.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd = shift[0], LSB first, each bit held CLKS_PER_BIT cycles. Shift right at each bit boundary. After bit index 7 completes, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the end:
    - FIFO non-empty: pop and go straight to START (txd=0 on that edge), giving zero idle cycles between frames.
    - FIFO empty: go to IDLE.
- Latency: a byte accepted into an empty FIFO while IDLE makes txd fall on the first rising edge after the accepting edge.
- Frame length: exactly 10*CLKS_PER_BIT clocks.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps, and generates a one-cycle bit-boundary strobe at terminal count. It runs only when not IDLE.
- tx_busy is registered and tracks the state: it rises together with the falling txd start edge and falls on the edge the FSM enters IDLE.

Decomposition:
- Package uart_pkg:
  - tx state enum (IDLE/START/DATA/STOP).
  - DATA_BITS=8.
  - function clks_per_bit(clk_freq, baud).
  - Shared with the future RX block.
- Sub-module uart_tx_fifo:
  - Parameters: WIDTH=8, DEPTH.
  - Signals: push/pop, full/empty, level.
  - Asynchronous active-high reset; read data combinational from the head entry.

Test Plan:
- Bench setup: CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16.
- Reset: assert rst mid-clock -> txd=1, tx_ready=1, tx_busy=0, fifo_level=0 immediately, without waiting for an edge.
- Single byte 0x35 -> txd falls 1 edge after acceptance. txd sequence is 0,1,0,1,0,1,1,0,0,1, each held 16 cycles. tx_busy is high for exactly 160 cycles.
- Burst 0x30..0x34 with tx_valid held high, FIFO_DEPTH=4:
  - First byte is popped immediately.
  - tx_ready drops when fifo_level=4.
  - All 5 frames go out back-to-back: 800 cycles, no idle-high gap beyond the stop bits.
  - Decoded order is "01234".
- Full FIFO plus STOP-end pop in the same cycle while tx_valid=1 -> push refused that cycle (tx_ready=0). The byte is accepted on the next edge and fifo_level returns to 4.
- Reset during DATA bit 3 of 0x61 -> txd=1 at once and fifo_level=0. After release, sending 0x66 yields a clean frame decoded as 'f'.
- Encoder-chained sweep: nibbles 0x0..0xF into the encoder, enc_out[7:0] into tx_data -> bench UART model decodes "0123456789abcdef" with no framing errors.
